a1csa_vlat_ctrl: RTL and testbench
==================================

// Module: a1csa_vlat_ctrl
// PURPOSE
//  Variable-latency controller for the block-speculative carry-select adder.
//  - Fast path (1 cycle): speculative sum, carry into each block predicted locally.
//  - Error check on the same cycle; on misprediction, one RECOV cycle produces the exact sum.
//  - Sits between operand producer and result consumer with valid/ready on both sides.
//  - Keeps a saturating count of mispredictions.
// PARAMETERS
//  N    16  operand/sum width; multiple of B
//  B    4   speculation block width; NB=N/B blocks
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  in_valid    in   1   operands a,b valid
//  in_ready    out  1   controller can accept operands
//  a           in   N   operand A
//  b           in   N   operand B
//  approx_only in   1   1 = never recover; sampled with operands
//  out_valid   out  1   sum/cout/err/recovered valid
//  out_ready   in   1   consumer accepts result
//  sum         out  N   result
//  cout        out  1   carry out of bit N-1
//  err         out  1   result is speculative and wrong (approx_only path only)
//  recovered   out  1   result came through the RECOV cycle
//  err_cnt     out  16  mispredictions since reset; saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; in_ready=1.
//    out_valid=0, sum=0, cout=0, err=0, recovered=0, err_cnt=0, operand regs=0.
//  - Speculation:
//    - Block k spans bits [kB+B-1:kB].
//    - Block 0 carry-in = 0.
//    - Block k>=1 carry-in = a[kB-1] & b[kB-1].
//    - Speculative sum = concat of per-block (a+b+cin_spec) mod 2^B.
//    - Speculative cout = carry out of block NB-1 with its speculative carry-in.
//  - mispredict = 1 iff, for any k>=1, cin_spec(k) differs from the true ripple carry
//    into bit kB. Exact sum = (a+b) mod 2^N; exact cout = bit N of a+b.
//  - FSM:
//    - IDLE: in_ready=1. On in_valid: latch a, b, approx_only -> CALC.
//    - CALC: in_ready=0; evaluate from latched operands.
//      - !mispredict: load spec sum/cout, err=0, recovered=0 -> DONE.
//      - mispredict & approx_only: load spec sum/cout, err=1, recovered=0, err_cnt+1 -> DONE.
//      - mispredict & !approx_only: err_cnt+1 -> RECOV.
//    - RECOV: load exact sum/cout, err=0, recovered=1 -> DONE.
//    - DONE: out_valid=1; outputs held stable while out_ready=0.
//      On out_ready: out_valid=0 -> IDLE.
//  - Latency, accept edge E0 to out_valid high: E1 no mispredict; E2 with recovery.
//    Throughput one op per 3 (fast) or 4 (recover) cycles minimum.
//  - Only one operation in flight; in_ready=0 in CALC/RECOV/DONE; in_valid ignored there.
//  - sum/cout/err/recovered change only on entering DONE; otherwise they keep the last result.
//  - err_cnt increments once per mispredicted op, at the CALC edge; no wrap.
//  - Reset mid-operation: op discarded; all state and outputs return to reset values immediately.
//  - Width rules: all arithmetic unsigned; per-block adds are B+1 bits wide.
// TESTING (N=16, B=4)
//  1. Reset, a=16'h0808 b=16'h0808 approx_only=0
//     -> out_valid 1 cycle after accept, sum=16'h1010 cout=0 err=0 recovered=0 err_cnt=0.
//  2. a=16'h000F b=16'h0001 approx_only=0
//     -> RECOV taken, out_valid 2 cycles after accept, sum=16'h0010 recovered=1 err_cnt=1.
//  3. Same operands, approx_only=1
//     -> out_valid after 1 cycle, sum=16'h0000 err=1 recovered=0, err_cnt increments.
//  4. a=16'hFFFF b=16'h0001 approx_only=0 -> sum=16'h0000 cout=1 recovered=1.
//     Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0.
//  5. Assert rst_n=0 during RECOV -> all outputs 0 the same cycle, state IDLE, next op accepted.
//  6. Force err_cnt to 16'hFFFE, run 3 mispredicting ops -> err_cnt=16'hFFFF and stays there.
//     Random compare against a+b, approx_only=0: sum always exact.

Source files
------------

// File: rtl/a1csa_vlat_ctrl.sv
// Variable-latency controller for a block-speculative carry-select adder.
// Each block of B bits predicts its carry-in from the top bit pair of the
// block below. That guess gives a one-cycle result. When any guess is wrong,
// one extra RECOV cycle loads the exact sum. The only exception is when the
// operation asked for the approximate answer, which is returned flagged with
// err. Valid/ready handshakes sit on both sides, and only one op is in flight.
module a1csa_vlat_ctrl #(
  parameter int N = 16,
  parameter int B = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         approx_only,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         err,
  output logic         recovered,
  output logic [15:0]  err_cnt
);

  localparam int NB = N / B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    RECOV = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]  a_q, b_q;
  logic          approx_q;

  logic [N:0]    exact;
  logic [N-1:0]  spec_sum;
  logic          spec_cout;
  logic [NB-1:0] cin_spec, cin_true;
  logic [B:0]    blk;
  logic          mispredict;

  logic latch_ops, load_spec, load_exact, inc_cnt;

  // Speculative and exact sums of the latched operands, plus the misprediction flag.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    exact     = {1'b0, a_q} + {1'b0, b_q};
    spec_sum  = '0;
    spec_cout = 1'b0;
    cin_spec  = '0;
    cin_true  = '0;
    blk       = '0;
    // Block 0 always sees carry-in 0, so only blocks 1..NB-1 predict.
    for (int k = 1; k < NB; k++) begin
      cin_spec[k] = a_q[k*B-1] & b_q[k*B-1];
      // The true ripple carry into bit kB is recovered from the exact sum bit.
      cin_true[k] = exact[k*B] ^ a_q[k*B] ^ b_q[k*B];
    end
    for (int k = 0; k < NB; k++) begin
      blk = {1'b0, a_q[k*B +: B]} + {1'b0, b_q[k*B +: B]} + {{B{1'b0}}, cin_spec[k]};
      spec_sum[k*B +: B] = blk[B-1:0];
      spec_cout          = blk[B];
    end
    mispredict = |(cin_spec ^ cin_true);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    else        state <= state_nxt;
  end

  // Next state and datapath load strobes.
  always_comb begin
    state_nxt  = state;
    latch_ops  = 1'b0;
    load_spec  = 1'b0;
    load_exact = 1'b0;
    inc_cnt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          latch_ops = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (!mispredict) begin
          load_spec = 1'b1;
          state_nxt = DONE;
        end else if (approx_q) begin
          load_spec = 1'b1;
          inc_cnt   = 1'b1;
          state_nxt = DONE;
        end else begin
          inc_cnt   = 1'b1;
          state_nxt = RECOV;
        end
      end
      RECOV: begin
        load_exact = 1'b1;
        state_nxt  = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand capture, result registers and saturating misprediction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are plain flops, not memories, so every one of them is reset.
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      approx_q  <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= 1'b0;
      recovered <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (latch_ops) begin
        a_q      <= a;
        b_q      <= b;
        approx_q <= approx_only;
      end
      if (load_spec) begin
        sum       <= spec_sum;
        cout      <= spec_cout;
        err       <= mispredict;
        recovered <= 1'b0;
      end
      if (load_exact) begin
        sum       <= exact[N-1:0];
        cout      <= exact[N];
        err       <= 1'b0;
        recovered <= 1'b1;
      end
      if (inc_cnt && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_a1csa_vlat_ctrl.sv
// Self-checking bench for a1csa_vlat_ctrl (N=16, B=4).
module tb_a1csa_vlat_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        approx_only = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        err;
  logic        recovered;
  logic [15:0] err_cnt;

  a1csa_vlat_ctrl #(.N(16), .B(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_only(approx_only),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err), .recovered(recovered),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ap;
    logic [15:0] sum;
    logic        cout;
    logic        err;
    logic        rec;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;
  vec_t        exp_q[$];
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent misprediction model: compare each block's guessed carry-in
  // with the carry out of the masked low-order sum.
  function automatic logic model_mis(input logic [15:0] x, input logic [15:0] y);
    logic        m;
    logic [15:0] mask;
    logic [16:0] s;
    m = 1'b0;
    for (int k = 1; k < 4; k++) begin
      mask = (16'h0001 << (4 * k)) - 16'h0001;
      s    = {1'b0, x & mask} + {1'b0, y & mask};
      if (s[4*k] != (x[4*k-1] & y[4*k-1])) m = 1'b1;
    end
    return m;
  endfunction

  // Drive one op, wait for its result and score it. Then hold the result for
  // `hold` cycles with out_ready low before draining it.
  task automatic run_op(input vec_t v, input int hold);
    int   lat;
    logic seen;
    logic mis;
    vec_t e;
    mis = model_mis(v.a, v.b);
    exp_q.push_back(v);
    if (mis && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    a = v.a; b = v.b; approx_only = v.ap; in_valid = 1'b1;
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = ~v.a; b = ~v.b; approx_only = ~v.ap;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) seen = 1'b1;
    end
    e = exp_q.pop_front();
    if (!seen) check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    check("latency", lat, (mis && !e.ap) ? 32'd2 : 32'd1);
    check("sum", {16'd0, sum}, {16'd0, e.sum});
    check("cout", {31'd0, cout}, {31'd0, e.cout});
    check("err", {31'd0, err}, {31'd0, e.err});
    check("recovered", {31'd0, recovered}, {31'd0, e.rec});
    check("err_cnt", {16'd0, err_cnt}, {16'd0, exp_cnt});
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h5555; b = 16'hAAAA;
      @(posedge clk);
      #1;
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_sum", {16'd0, sum}, {16'd0, e.sum});
      check("hold_cout", {31'd0, cout}, {31'd0, e.cout});
      check("hold_recovered", {31'd0, recovered}, {31'd0, e.rec});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    //            a         b         ap    sum       cout  err   rec
    vecs[0] = '{16'h0808, 16'h0808, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{16'h000F, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h00F0, 16'h0010, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};

    // Reset state.
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors; the FFFF+0001 recovery case is held for 5 cycles.
    for (int i = 0; i < 8; i++) run_op(vecs[i], (i == 3) ? 5 : 0);

    // Random exact-mode ops: sum must always equal a+b.
    for (int i = 0; i < 20; i++) begin
      logic [16:0] s;
      v.a  = 16'($urandom);
      v.b  = 16'($urandom);
      v.ap = 1'b0;
      s    = {1'b0, v.a} + {1'b0, v.b};
      v.sum  = s[15:0];
      v.cout = s[16];
      v.err  = 1'b0;
      v.rec  = model_mis(v.a, v.b);
      run_op(v, 0);
    end

    // Reset while in RECOV: everything returns to reset values at once.
    @(negedge clk);
    a = 16'h000F; b = 16'h0001; approx_only = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("recov_busy_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sum", {16'd0, sum}, 32'd0);
    check("mid_rst_cout", {31'd0, cout}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_recovered", {31'd0, recovered}, 32'd0);
    check("mid_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vecs[0], 0);
    run_op(vecs[3], 0);

    // Saturation: preload the counter near its ceiling, then mispredict three times.
    @(negedge clk);
    force dut.err_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) run_op(vecs[1 + i], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
